ram_cmd_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port RAM command interface (10-bit command words, 8-bit read data) between the SPI slave and a second local requester. It grants the RAM with round-robin fairness and holds the grant atomically from an address command until the matching data command completes. Read data is routed back only to the owning requester. A lock timeout recovers the RAM if a requester stalls while holding the grant.

---
 rtl/ram_cmd_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: shares one single-port RAM command interface between two
// requesters (A = SPI slave, B = local port). Round-robin on ties, grant held
// from an address command until the matching data command completes, read
// data routed only to the owner, and a lock timeout that recovers the RAM
// from a stalled owner.
module ram_cmd_arbiter #(
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] a_din,
  input  logic       a_valid,
  output logic       a_ready,
  output logic [7:0] a_rdata,
  output logic       a_rvalid,
  input  logic [9:0] b_din,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] b_rdata,
  output logic       b_rvalid,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       err_timeout
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  // Last idle count before the limit: reaching LOCK_TIMEOUT on this cycle's
  // increment is what releases the lock.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RD_WAIT = 2'b10
  } state_t;

  // Where an accepted command leaves the arbiter; identical from IDLE and GRANT.
  function automatic state_t next_from_op(input logic [1:0] op);
    state_t nxt;
    case (op)
      OP_WR_ADDR: nxt = ST_GRANT;
      OP_RD_ADDR: nxt = ST_GRANT;
      OP_WR_DATA: nxt = ST_IDLE;
      OP_RD_DATA: nxt = ST_RD_WAIT;
      default:    nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  state_t           state_r, state_s;
  logic             owner_r, owner_s;
  logic             last_grant_r, last_grant_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  logic             sel_s;
  logic [9:0]       cmd_s;
  logic             hs_s;
  logic             timeout_s;
  logic             rd_done_s;
  logic             a_ready_s, b_ready_s;

  logic [9:0]       ram_din_r;
  logic             ram_rx_valid_r;
  logic [7:0]       a_rdata_r, b_rdata_r;
  logic             a_rvalid_r, b_rvalid_r;
  logic             err_timeout_r;

  // Arbitration, handshake detection, lock counter and next-state decode.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    sel_s        = owner_r;
    cmd_s        = a_din;
    hs_s         = 1'b0;
    timeout_s    = 1'b0;
    rd_done_s    = 1'b0;
    a_ready_s    = 1'b0;
    b_ready_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (a_valid && b_valid) begin
          sel_s = ~last_grant_r;
        end else if (b_valid) begin
          sel_s = SEL_B;
        end else begin
          sel_s = SEL_A;
        end
        cmd_s = (sel_s == SEL_B) ? b_din : a_din;
        if (a_valid || b_valid) begin
          a_ready_s    = (sel_s == SEL_A);
          b_ready_s    = (sel_s == SEL_B);
          hs_s         = 1'b1;
          owner_s      = sel_s;
          last_grant_s = sel_s;
          state_s      = next_from_op(cmd_s[9:8]);
        end else begin
          hs_s = 1'b0;
        end
      end
      ST_GRANT: begin
        sel_s     = owner_r;
        cmd_s     = (owner_r == SEL_B) ? b_din : a_din;
        a_ready_s = (owner_r == SEL_A);
        b_ready_s = (owner_r == SEL_B);
        if ((owner_r == SEL_B) ? b_valid : a_valid) begin
          hs_s    = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = next_from_op(cmd_s[9:8]);
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          cnt_s     = CNT_ZERO;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RD_WAIT: begin
        // Data arriving on the limit cycle takes priority over the timeout.
        if (ram_tx_valid) begin
          rd_done_s = 1'b1;
          cnt_s     = CNT_ZERO;
          state_s   = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          cnt_s     = CNT_ZERO;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, ownership and lock counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= SEL_A;
      last_grant_r <= SEL_B;
      cnt_r        <= CNT_ZERO;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
    end
  end

  // Registered RAM command, read-data return and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_din_r      <= 10'h000;
      ram_rx_valid_r <= 1'b0;
      a_rdata_r      <= 8'h00;
      b_rdata_r      <= 8'h00;
      a_rvalid_r     <= 1'b0;
      b_rvalid_r     <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      ram_rx_valid_r <= hs_s;
      if (hs_s) begin
        ram_din_r <= cmd_s;
      end
      a_rvalid_r    <= rd_done_s && (owner_r == SEL_A);
      b_rvalid_r    <= rd_done_s && (owner_r == SEL_B);
      if (rd_done_s && (owner_r == SEL_A)) begin
        a_rdata_r <= ram_dout;
      end
      if (rd_done_s && (owner_r == SEL_B)) begin
        b_rdata_r <= ram_dout;
      end
      err_timeout_r <= timeout_s;
    end
  end

  assign a_ready      = a_ready_s;
  assign b_ready      = b_ready_s;
  assign ram_din      = ram_din_r;
  assign ram_rx_valid = ram_rx_valid_r;
  assign a_rdata      = a_rdata_r;
  assign b_rdata      = b_rdata_r;
  assign a_rvalid     = a_rvalid_r;
  assign b_rvalid     = b_rvalid_r;
  assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with LOCK_TIMEOUT = 8: a per-cycle vector
// table plus hand-written reset sequences.
module tb_ram_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] a_din, b_din;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] a_rdata, b_rdata;
  logic       a_rvalid, b_rvalid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  ram_cmd_arbiter #(.LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_din(a_din), .a_valid(a_valid), .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_din(b_din), .b_valid(b_valid), .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Registered outputs packed as {ram_din, rx_valid, a_rdata, a_rvalid, b_rdata, b_rvalid, err}
  logic [29:0] act_o;
  assign act_o = {ram_din, ram_rx_valid, a_rdata, a_rvalid, b_rdata, b_rvalid, err_timeout};

  typedef struct {
    logic [9:0]  ad;
    logic        av;
    logic [9:0]  bd;
    logic        bv;
    logic [7:0]  rd;
    logic        tv;
    logic        ck;   // readies defined on this row
    logic [1:0]  ry;   // {a_ready, b_ready}
    logic [29:0] eo;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  function automatic logic [29:0] pk(input logic [9:0] d, input logic rx, input logic [7:0] ar,
                                     input logic arv, input logic [7:0] br, input logic brv,
                                     input logic e);
    return {d, rx, ar, arv, br, brv, e};
  endfunction

  task automatic add(input logic [9:0] ad, input logic av, input logic [9:0] bd, input logic bv,
                     input logic [7:0] rd, input logic tv, input logic ck, input logic [1:0] ry,
                     input logic [29:0] eo);
    vecs[nv] = '{ad, av, bd, bv, rd, tv, ck, ry, eo};
    nv++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_din = 10'h000; a_valid = 1'b0;
    b_din = 10'h000; b_valid = 1'b0;
    ram_dout = 8'h00; ram_tx_valid = 1'b0;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Locked write from A while B waits; B then wins the next tie.
    add(10'h03C,1'b1,10'h0AB,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h000,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h1A5,1'b1,10'h0AB,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h03C,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h044,1'b1,10'h0AB,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h1A5,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h044,1'b1,10'h1CD,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h0AB,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h044,1'b1,10'h0F0,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h1CD,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    // A read: address, re-address, read data, RAM answers one cycle after rx_valid.
    add(10'h2C1,1'b1,10'h0F0,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h044,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h300,1'b1,10'h0F0,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h2C1,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h0F0,1'b1,8'h00,1'b0,1'b1,2'b00, pk(10'h300,1'b1,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h0F0,1'b1,8'h3E,1'b1,1'b1,2'b00, pk(10'h300,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h0F0,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h300,1'b0,8'h3E,1'b1,8'h00,1'b0,1'b0));
    // B read 0x23C / 0x300, RAM returns 0xA5.
    add(10'h000,1'b0,10'h23C,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h0F0,1'b1,8'h3E,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h300,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h23C,1'b1,8'h3E,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b1,2'b00, pk(10'h300,1'b1,8'h3E,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'hA5,1'b1,1'b1,2'b00, pk(10'h300,1'b0,8'h3E,1'b0,8'h00,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b0,2'b00, pk(10'h300,1'b0,8'h3E,1'b0,8'hA5,1'b1,1'b0));
    // Stray RAM data in IDLE is ignored.
    add(10'h000,1'b0,10'h000,1'b0,8'h77,1'b1,1'b0,2'b00, pk(10'h300,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b0,2'b00, pk(10'h300,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    // Unlocked write data 0x1FF from A, B granted next cycle.
    add(10'h1FF,1'b1,10'h0AB,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h300,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h1AB,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h1FF,1'b1,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    // Lock timeout in GRANT: A addresses 0x010 then stalls for 8 cycles.
    add(10'h010,1'b1,10'h000,1'b0,8'h00,1'b0,1'b1,2'b10, pk(10'h1AB,1'b1,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h0C3,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h010,1'b1,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    for (int k = 0; k < 7; k++)
      add(10'h000,1'b0,10'h0C3,1'b1,8'h00,1'b0,1'b1,2'b10, pk(10'h010,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h0C3,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h010,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b1));
    add(10'h000,1'b0,10'h1C3,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h0C3,1'b1,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    // Read data straight from IDLE; RAM answers exactly on the limit cycle, data wins.
    add(10'h311,1'b1,10'h000,1'b0,8'h00,1'b0,1'b1,2'b10, pk(10'h1C3,1'b1,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b1,2'b00, pk(10'h311,1'b1,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    for (int k = 0; k < 6; k++)
      add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b1,2'b00, pk(10'h311,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h99,1'b1,1'b1,2'b00, pk(10'h311,1'b0,8'h3E,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b0,2'b00, pk(10'h311,1'b0,8'h99,1'b1,8'hA5,1'b0,1'b0));
    // RD_WAIT timeout: B reads, RAM never answers; late data afterwards is ignored.
    add(10'h000,1'b0,10'h3EE,1'b1,8'h00,1'b0,1'b1,2'b01, pk(10'h311,1'b0,8'h99,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b1,2'b00, pk(10'h3EE,1'b1,8'h99,1'b0,8'hA5,1'b0,1'b0));
    for (int k = 0; k < 7; k++)
      add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b1,2'b00, pk(10'h3EE,1'b0,8'h99,1'b0,8'hA5,1'b0,1'b0));
    add(10'h000,1'b0,10'h000,1'b0,8'h11,1'b1,1'b0,2'b00, pk(10'h3EE,1'b0,8'h99,1'b0,8'hA5,1'b0,1'b1));
    add(10'h000,1'b0,10'h000,1'b0,8'h00,1'b0,1'b0,2'b00, pk(10'h3EE,1'b0,8'h99,1'b0,8'hA5,1'b0,1'b0));

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n   = 1'b0;
    a_din   = 10'h03C; a_valid = 1'b1;
    b_din   = 10'h0AB; b_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("reset readies", {30'd0, a_ready, b_ready}, {30'd0, 2'b10});
    check("reset outputs", {2'b00, act_o}, 32'h0000_0000);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table ----------------
    for (int i = 0; i < nv; i++) begin
      a_din = vecs[i].ad; a_valid = vecs[i].av;
      b_din = vecs[i].bd; b_valid = vecs[i].bv;
      ram_dout = vecs[i].rd; ram_tx_valid = vecs[i].tv;
      @(negedge clk);
      if (vecs[i].ck)
        check($sformatf("row%0d readies", i), {30'd0, a_ready, b_ready}, {30'd0, vecs[i].ry});
      check($sformatf("row%0d outputs", i), {2'b00, act_o}, {2'b00, vecs[i].eo});
      @(posedge clk); #1;
    end

    // ---------------- reset during RD_WAIT ----------------
    idle_inputs();
    a_din = 10'h3AA; a_valid = 1'b1;
    @(negedge clk);
    check("rdwait a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("rdwait cmd", {22'd0, ram_din}, {22'd0, 10'h3AA});
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {2'b00, act_o}, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ram_dout = 8'h5A; ram_tx_valid = 1'b1;
    @(posedge clk); #1;
    ram_tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post reset late data %0d", k), {2'b00, act_o}, 32'h0000_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
